bomb_manager: RTL

//  Downstream of player_move: takes the player's topLeftX/topLeftY and the drop_bomb key.

---
 rtl/bomb_manager.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bomb_manager.sv
// Single-bomb manager: snaps a bomb to the tile grid under the player, runs the fuse, then the blast.
// Optional feature macro: BOMB_CHAIN_DETONATE_EN (blast_hit detonates a fused bomb early).
module bomb_manager #(
   parameter int GRID_X0      = 15,
   parameter int GRID_Y0      = 48,
   parameter int TILE_SIZE    = 32,
   parameter int GRID_COLS    = 19,
   parameter int GRID_ROWS    = 13,
   parameter int FUSE_FRAMES  = 90,
   parameter int BLAST_FRAMES = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic               drop_bomb,
   input  logic signed [10:0] playerTopLeftX,
   input  logic signed [10:0] playerTopLeftY,
   input  logic [1:0]         range_level,
   input  logic               blast_hit,
   output logic signed [10:0] bombTopLeftX,
   output logic signed [10:0] bombTopLeftY,
   output logic               bomb_active,
   output logic               exploding,
   output logic               explode_pulse,
   output logic [2:0]         blast_range,
   output logic [7:0]         fuse_remaining
);

   localparam int SHIFT = $clog2(TILE_SIZE);
   localparam logic signed [11:0] X_OFF   = 12'(TILE_SIZE / 2 - GRID_X0);
   localparam logic signed [11:0] Y_OFF   = 12'(TILE_SIZE / 2 - GRID_Y0);
   localparam logic signed [11:0] COL_MAX = 12'(GRID_COLS - 1);
   localparam logic signed [11:0] ROW_MAX = 12'(GRID_ROWS - 1);
   localparam logic [7:0] FUSE_INIT  = 8'(FUSE_FRAMES);
   localparam logic [7:0] BLAST_INIT = 8'(BLAST_FRAMES);

   typedef enum logic [1:0] {
      IDLE_ST,
      FUSE_ST,
      BLAST_ST
   } state_t;

   state_t             state;
   logic               drop_bomb_d;
   logic [7:0]         blast_cnt;
   logic               drop_req_c;
   logic               detonate_c;
   logic signed [11:0] col_raw_c;
   logic signed [11:0] row_raw_c;
   logic [11:0]        col_c;
   logic [11:0]        row_c;
   logic signed [10:0] snap_x_c;
   logic signed [10:0] snap_y_c;

   assign drop_req_c = drop_bomb & ~drop_bomb_d;

`ifdef BOMB_CHAIN_DETONATE_EN
   assign detonate_c = (state == FUSE_ST) &&
                       (blast_hit || (startOfFrame && (fuse_remaining == 8'd1)));
`else
   logic unused_blast_hit;
   assign unused_blast_hit = blast_hit;
   assign detonate_c = (state == FUSE_ST) && startOfFrame && (fuse_remaining == 8'd1);
`endif

   // Tile under the player's centre, clamped to the playfield
   always_comb begin
      col_raw_c = ($signed({playerTopLeftX[10], playerTopLeftX}) + X_OFF) >>> SHIFT;
      row_raw_c = ($signed({playerTopLeftY[10], playerTopLeftY}) + Y_OFF) >>> SHIFT;
      col_c = col_raw_c;
      row_c = row_raw_c;
      if (col_raw_c < 12'sd0)        col_c = '0;
      else if (col_raw_c > COL_MAX)  col_c = COL_MAX;
      if (row_raw_c < 12'sd0)        row_c = '0;
      else if (row_raw_c > ROW_MAX)  row_c = ROW_MAX;
      snap_x_c = 11'(12'(GRID_X0) + (col_c << SHIFT));
      snap_y_c = 11'(12'(GRID_Y0) + (row_c << SHIFT));
   end

   // fuse_remaining doubles as the fuse counter; it reads 0 outside FUSE_ST
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE_ST;
         drop_bomb_d    <= 1'b0;
         blast_cnt      <= '0;
         bombTopLeftX   <= '0;
         bombTopLeftY   <= '0;
         bomb_active    <= 1'b0;
         exploding      <= 1'b0;
         explode_pulse  <= 1'b0;
         blast_range    <= '0;
         fuse_remaining <= '0;
      end else begin
         drop_bomb_d   <= drop_bomb;
         explode_pulse <= 1'b0;
         case (state)
            IDLE_ST: begin
               if (drop_req_c) begin
                  state          <= FUSE_ST;
                  bombTopLeftX   <= snap_x_c;
                  bombTopLeftY   <= snap_y_c;
                  blast_range    <= 3'(range_level) + 3'd1;
                  fuse_remaining <= FUSE_INIT;
                  bomb_active    <= 1'b1;
               end
            end
            FUSE_ST: begin
               if (detonate_c) begin
                  state          <= BLAST_ST;
                  bomb_active    <= 1'b0;
                  exploding      <= 1'b1;
                  explode_pulse  <= 1'b1;
                  fuse_remaining <= '0;
                  blast_cnt      <= BLAST_INIT;
               end else if (startOfFrame) begin
                  fuse_remaining <= fuse_remaining - 8'd1;
               end
            end
            BLAST_ST: begin
               if (startOfFrame) begin
                  if (blast_cnt == 8'd1) begin
                     state     <= IDLE_ST;
                     exploding <= 1'b0;
                     blast_cnt <= '0;
                  end else begin
                     blast_cnt <= blast_cnt - 8'd1;
                  end
               end
            end
            default: state <= IDLE_ST;
         endcase
      end
   end

endmodule
